// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the MDU front-end controller.
//   - md_class_e  : E-stage MD instruction class codes (4 bits)
//   - mdu_op_e    : opcodes presented to the iterative MDU (3 bits)
//   - mdu_state_e : controller FSM states
//   - mdu_cmd_t   : one MDU command (opcode plus two operands)
//   - md_to_op()  : class to opcode mapping, MDU_NONE for non-write classes
//   - md_is_wr()  : true for classes that produce an MDU command
package mdu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_class_e;

    typedef enum logic [OP_W-1:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_RUN_PEND = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } mdu_cmd_t;

    function automatic logic [OP_W-1:0] md_to_op(input logic [3:0] cls);
        case (cls)
            MD_MULT:  return MDU_MULT;
            MD_MULTU: return MDU_MULTU;
            MD_DIV:   return MDU_DIV;
            MD_DIVU:  return MDU_DIVU;
            MD_MTHI:  return MDU_MTHI;
            MD_MTLO:  return MDU_MTLO;
            default:  return MDU_NONE;
        endcase
    endfunction

    // Read-class (mfhi/mflo) and non-MD codes map to MDU_NONE.
    function automatic logic md_is_wr(input logic [3:0] cls);
        return md_to_op(cls) != MDU_NONE;
    endfunction

endpackage

// File: rtl/mdu_cmd_reg.sv
// mdu_cmd_reg: one-entry MDU command register with load and clear.
//   clk    : clock, rising edge
//   res    : asynchronous active-high reset, clears valid and payload
//   ld     : capture cmd_in and set valid (wins over clr)
//   clr    : drop valid; payload holds its last value
//   cmd_in : command to capture
//   valid  : entry holds a command
//   cmd    : stored command
module mdu_cmd_reg
    import mdu_pkg::*;
(
    input  logic     clk,
    input  logic     res,
    input  logic     ld,
    input  logic     clr,
    input  mdu_cmd_t cmd_in,
    output logic     valid,
    output mdu_cmd_t cmd
);

    logic     valid_q;
    mdu_cmd_t cmd_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            valid_q <= 1'b0;
            cmd_q   <= '0;
        end else if (ld) begin
            valid_q <= 1'b1;
            cmd_q   <= cmd_in;
        end else if (clr) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign cmd   = cmd_q;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: front end between the E stage and the iterative MDU.
// Issues multiply/divide/mthi/mtlo commands through registered start/op/operands,
// buffers one command while the MDU is occupied, stalls D for MD-class hazards,
// selects HI/LO for mfhi/mflo and counts stalled cycles.
//   clk, res    : clock and asynchronous active-high reset (shared with the MDU)
//   e_md_op     : E-stage MD class (md_class_e)
//   e_rs, e_rt  : forwarded E-stage operands
//   d_md_wr     : D holds mult/multu/div/divu/mthi/mtlo
//   d_md_rd     : D holds mfhi/mflo
//   stall_d     : freeze F/D, bubble into E
//   mdu_start   : one-cycle command pulse to the MDU
//   mdu_op      : MDU opcode (holds when idle)
//   mdu_a/b     : MDU operands (hold when idle)
//   mdu_busy    : MDU busy
//   mdu_hi/lo   : MDU HI/LO registers
//   e_mf_data   : HI for mfhi, LO for mflo, else 0
//   stall_cnt   : wrapping count of cycles with stall_d high
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              res,
    input  logic [3:0]        e_md_op,
    input  logic [31:0]       e_rs,
    input  logic [31:0]       e_rt,
    input  logic              d_md_wr,
    input  logic              d_md_rd,
    output logic              stall_d,
    output logic              mdu_start,
    output logic [2:0]        mdu_op,
    output logic [31:0]       mdu_a,
    output logic [31:0]       mdu_b,
    input  logic              mdu_busy,
    input  logic [31:0]       mdu_hi,
    input  logic [31:0]       mdu_lo,
    output logic [31:0]       e_mf_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    mdu_state_e       state_q, state_d;
    logic             e_wr;
    logic             free;
    logic             issue_ld;
    logic             issue_valid;
    logic             pend_ld;
    logic             pend_clr;
    logic             pend_valid;
    mdu_cmd_t         e_cmd;
    mdu_cmd_t         issue_src;
    mdu_cmd_t         issue_cmd;
    mdu_cmd_t         pend_cmd;
    logic [CNT_W-1:0] stall_cnt_q;

    assign e_wr = md_is_wr(e_md_op);

    always_comb begin
        e_cmd    = '0;
        e_cmd.op = md_to_op(e_md_op);
        e_cmd.a  = e_rs;
        e_cmd.b  = e_rt;
    end

    // The registered start counts as occupancy: the MDU only raises busy a
    // cycle after it sees start.
    assign free = !issue_valid && !mdu_busy;

    always_comb begin
        state_d   = state_q;
        issue_ld  = 1'b0;
        issue_src = e_cmd;
        pend_ld   = 1'b0;
        pend_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (e_wr) begin
                    issue_ld = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (free) begin
                    if (e_wr) begin
                        issue_ld = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (e_wr) begin
                    pend_ld = 1'b1;
                    state_d = S_RUN_PEND;
                end
            end
            S_RUN_PEND: begin
                // D is stalled while pending is full, so E carries no write here.
                if (free) begin
                    issue_ld  = 1'b1;
                    issue_src = pend_cmd;
                    pend_clr  = 1'b1;
                    state_d   = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue register: valid is the start pulse, cleared every cycle it is not
    // reloaded; the payload holds so op/a/b stay stable between commands.
    mdu_cmd_reg u_issue (
        .clk    (clk),
        .res    (res),
        .ld     (issue_ld),
        .clr    (1'b1),
        .cmd_in (issue_src),
        .valid  (issue_valid),
        .cmd    (issue_cmd)
    );

    mdu_cmd_reg u_pend (
        .clk    (clk),
        .res    (res),
        .ld     (pend_ld),
        .clr    (pend_clr),
        .cmd_in (e_cmd),
        .valid  (pend_valid),
        .cmd    (pend_cmd)
    );

    assign mdu_start = issue_valid;
    assign mdu_op    = issue_cmd.op;
    assign mdu_a     = issue_cmd.a;
    assign mdu_b     = issue_cmd.b;

    // Reads wait for every outstanding or in-flight write; writes wait only
    // when they could not be accepted into the one-deep buffer.
    assign stall_d = (d_md_rd && (issue_valid || mdu_busy || pend_valid || e_wr)) ||
                     (d_md_wr && (pend_valid || (e_wr && !free)));

    always_comb begin
        e_mf_data = '0;
        case (e_md_op)
            MD_MFHI: e_mf_data = mdu_hi;
            MD_MFLO: e_mf_data = mdu_lo;
            default: e_mf_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            stall_cnt_q <= '0;
        end else if (stall_d) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Front-end controller between the pipeline's E stage and the iterative MDU.
- Accepts multiply, divide and HI/LO-write commands from E and issues them to the MDU through registered `start`/`MDU_op`/`A`/`B`.
- Holds one pending command while the MDU is busy.
- Generates the D-stage stall for MD-class instructions and muxes HI/LO for `mfhi`/`mflo`.
- Counts MD stall cycles for performance reporting.

## Interface
- `CNT_W`, default 32: width of the stall-cycle counter.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `res` in 1: reset, asynchronous and active-high; also drives the MDU's `res`.
- `e_md_op` in 4: E-stage MD class from `mdu_pkg`: `MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`, `MD_MFHI`, `MD_MFLO`.
- `e_rs` in 32: forwarded rs value in E.
- `e_rt` in 32: forwarded rt value in E.
- `d_md_wr` in 1: D-stage instruction is mult/multu/div/divu/mthi/mtlo.
- `d_md_rd` in 1: D-stage instruction is mfhi/mflo.
- `stall_d` out 1: freeze F/D and insert a bubble into E.
- `mdu_start` out 1: registered start pulse to the MDU.
- `mdu_op` out 3: registered MDU opcode.
- `mdu_a` out 32: registered operand A.
- `mdu_b` out 32: registered operand B.
- `mdu_busy` in 1: MDU busy.
- `mdu_hi` in 32: MDU HI register.
- `mdu_lo` in 32: MDU LO register.
- `e_mf_data` out 32: HI for `MD_MFHI`, LO for `MD_MFLO`, 0 otherwise; combinational.
- `stall_cnt` out CNT_W: number of cycles with `stall_d` high; wraps.

## Operation
- Write class: `MD_MULT`..`MD_MTLO`. Read class: `MD_MFHI`/`MD_MFLO`, which never produce an MDU command.
- Write class maps to `mdu_op` via `mdu_pkg`: `MULT`=1, `MULTU`=2, `DIV`=3, `DIVU`=4, `MTHI`=5, `MTLO`=6. `mdu_a`=`e_rs`, `mdu_b`=`e_rt`.
- `free` = !`mdu_start` && !`mdu_busy`, using the registered `mdu_start`. The MDU raises busy the cycle after `start` for mult/div, and never raises it for mthi/mtlo.
- FSM states (`mdu_pkg`): `S_IDLE`, `S_RUN`, `S_RUN_PEND`.
  - `S_IDLE`: a write-class E op issues next cycle (`mdu_start`=1) and the FSM goes to `S_RUN`.
  - `S_RUN`, `free` and a write-class E op: issue it, stay in `S_RUN`.
  - `S_RUN`, `free` and no E op: go to `S_IDLE`.
  - `S_RUN`, not `free` and a write-class E op: latch the op into the pending register, go to `S_RUN_PEND`.
  - `S_RUN_PEND`, `free`: issue the pending command, clear it, go to `S_RUN`.
- `stall_d` = (`d_md_rd` && (`mdu_start` || `mdu_busy` || `pend_valid` || E write-class)) || (`d_md_wr` && (`pend_valid` || (E write-class && !`free`))).
- The stall rule guarantees that no write-class E op arrives in `S_RUN_PEND`. The bench asserts this.
- `mdu_start` is a one-cycle pulse per command. Opcode and operands hold their last value when `mdu_start`=0.
- Back-to-back writes are legal; HI/LO ordering follows program order because issue is strictly FIFO with depth 1.

## Timing
- Reset values:
  - state `S_IDLE`, `pend_valid`=0, `mdu_start`=0;
  - `mdu_op`=0, `mdu_a`=0, `mdu_b`=0, `stall_cnt`=0;
  - `stall_d` follows its equation, so it is 0 in reset with D idle.
- Issue latency from E (idle): 1 cycle. E op in cycle t gives `mdu_start` in t+1.
- From pending: `mdu_start` in the cycle after `free` is observed.
- mthi in E at t: start at t+1, HI updated at the t+1 edge. An mfhi held in D is released at t+2 and reads the new HI in E at t+3.
- Reset mid-operation (pending full, MDU busy): everything clears immediately and the pending command is discarded; the MDU resets on the same `res`.
- `stall_cnt` increments the cycle after each cycle with `stall_d`=1, and wraps at 2^CNT_W.

## Structure
- `mdu_pkg` holds:
  - the `MD_*` E-stage class codes;
  - the `MDU_*` opcodes;
  - the FSM state encodings;
  - the class→opcode mapping function.
- Sub-module `mdu_cmd_reg` is a one-entry command register (valid, op, a, b) with load/clear. It is instantiated twice: once as the issue register, once as the pending register.

## Test plan
Behavioural MDU model: busy 5 cycles for mult, 10 for div.
- Reset with `res`=1 mid-stream → `mdu_start`=0, `stall_d`=0 with D idle, `stall_cnt`=0. A command accepted just before reset is never issued.
- DIV, `e_rs`=126, `e_rt`=0xFFFFFFF8, then MFLO in D → one `mdu_start` with `mdu_op`=3. `stall_d` stays high until busy drops. `e_mf_data`=0xFFFFFFF1 (LO); MFHI then gives 6.
- MULT 3×4 followed immediately by MTHI 0x55 → MTHI enters pending (`S_RUN_PEND`). A third write in D stalls. MTHI issues on `free`. The next MFHI returns 0x55 and MFLO returns 12.
- MTLO 0xA5 then MFLO in D → 2 stall cycles, `e_mf_data`=0xA5, no busy observed.
- Busy MDU plus pending full, with `d_md_wr` and `d_md_rd` toggling → `stall_d` matches its equation every cycle; `stall_cnt` equals the stalled-cycle count.
- Non-MD traffic with `mdu_busy`=1 → `stall_d`=0.
